// File: rtl/rom_arb_defs.sv
// Shared definitions for the ROM bus arbiter: FSM encoding, bank/requester counts, default widths.
package rom_arb_defs;

   localparam int NUM_BANKS  = 2;
   localparam int NUM_REQ    = 2;
   localparam int DEF_ADDR_W = 3;
   localparam int DEF_DATA_W = 8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      READ = 2'd1,
      DONE = 2'd2
   } state_t;

   function automatic logic [NUM_BANKS-1:0] bank_onehot(input logic bank);
      return bank ? 2'b10 : 2'b01;
   endfunction

endpackage

// File: rtl/rom_rr_picker.sv
// Two-input round-robin picker: on a tie the requester other than last wins; a lone request always wins.
module rom_rr_picker (
   input  logic req0,
   input  logic req1,
   input  logic last,
   output logic grant_id,
   output logic any_req
);

   assign any_req  = req0 | req1;
   assign grant_id = (req0 & req1) ? ~last : req1;

endmodule

// File: rtl/rom_bus_arbiter.sv
// Shares two ROM banks on one data bus between two requesters; 3-cycle read, registered outputs.
// ROM_ARB_FIXED_PRIO_EN: when defined, req0 always wins ties (no round-robin pointer).
module rom_bus_arbiter
   import rom_arb_defs::*;
#(
   parameter int ADDR_W = DEF_ADDR_W,
   parameter int DATA_W = DEF_DATA_W
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 req0,
   input  logic                 req1,
   input  logic [ADDR_W:0]      addr0,
   input  logic [ADDR_W:0]      addr1,
   output logic                 ack0,
   output logic                 ack1,
   output logic [DATA_W-1:0]    rdata,
   output logic                 rvalid,
   output logic                 rid,
   output logic [NUM_BANKS-1:0] cs,
   output logic                 read_en,
   output logic [ADDR_W-1:0]    rom_addr,
   input  logic [DATA_W-1:0]    rom_data
);

   state_t               state_q, state_d;
   logic                 winner_q, winner_d;
   logic [NUM_BANKS-1:0] cs_q, cs_d;
   logic                 read_en_q, read_en_d;
   logic [ADDR_W-1:0]    rom_addr_q, rom_addr_d;
   logic [DATA_W-1:0]    rdata_q, rdata_d;
   logic                 rvalid_q, rvalid_d;
   logic                 rid_q, rid_d;
   logic [NUM_REQ-1:0]   ack_q, ack_d;

   logic                 last_pick;
   logic                 grant_id;
   logic                 any_req;
   logic [ADDR_W:0]      sel_addr;

`ifdef ROM_ARB_FIXED_PRIO_EN
   assign last_pick = 1'b1;
`else
   logic last_q, last_d;

   assign last_pick = last_q;

   always_comb begin
      last_d = last_q;
      if (state_q == IDLE && any_req) begin
         last_d = grant_id;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         last_q <= 1'b1;
      end else begin
         last_q <= last_d;
      end
   end
`endif

   rom_rr_picker u_picker (
      .req0     (req0),
      .req1     (req1),
      .last     (last_pick),
      .grant_id (grant_id),
      .any_req  (any_req)
   );

   assign sel_addr = grant_id ? addr1 : addr0;

   // cs_q and rom_addr_q double as the latched bank and address for the read.
   always_comb begin
      state_d    = state_q;
      winner_d   = winner_q;
      cs_d       = cs_q;
      read_en_d  = read_en_q;
      rom_addr_d = rom_addr_q;
      rdata_d    = rdata_q;
      rvalid_d   = 1'b0;
      rid_d      = rid_q;
      ack_d      = '0;
      case (state_q)
         IDLE: begin
            if (any_req) begin
               winner_d   = grant_id;
               cs_d       = bank_onehot(sel_addr[ADDR_W]);
               read_en_d  = 1'b1;
               rom_addr_d = sel_addr[ADDR_W-1:0];
               state_d    = READ;
            end
         end
         READ: begin
            rdata_d         = rom_data;
            cs_d            = '0;
            read_en_d       = 1'b0;
            rvalid_d        = 1'b1;
            rid_d           = winner_q;
            ack_d[winner_q] = 1'b1;
            state_d         = DONE;
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            cs_d      = '0;
            read_en_d = 1'b0;
            state_d   = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         winner_q   <= 1'b0;
         cs_q       <= '0;
         read_en_q  <= 1'b0;
         rom_addr_q <= '0;
         rdata_q    <= '0;
         rvalid_q   <= 1'b0;
         rid_q      <= 1'b0;
         ack_q      <= '0;
      end else begin
         state_q    <= state_d;
         winner_q   <= winner_d;
         cs_q       <= cs_d;
         read_en_q  <= read_en_d;
         rom_addr_q <= rom_addr_d;
         rdata_q    <= rdata_d;
         rvalid_q   <= rvalid_d;
         rid_q      <= rid_d;
         ack_q      <= ack_d;
      end
   end

   assign cs       = cs_q;
   assign read_en  = read_en_q;
   assign rom_addr = rom_addr_q;
   assign rdata    = rdata_q;
   assign rvalid   = rvalid_q;
   assign rid      = rid_q;
   assign ack0     = ack_q[0];
   assign ack1     = ack_q[1];

endmodule

// File: tb/tb_rom_bus_arbiter.sv
// Self-checking bench for rom_bus_arbiter with a two-bank ROM model and an expected-read queue.
module tb_rom_bus_arbiter;
   import rom_arb_defs::*;

   typedef struct packed {
      logic       id;
      logic [7:0] data;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       req0 = 1'b0, req1 = 1'b0;
   logic [3:0] addr0 = '0, addr1 = '0;
   logic       ack0, ack1, rvalid, rid, read_en;
   logic [7:0] rdata, rom_data;
   logic [1:0] cs;
   logic [2:0] rom_addr;

   logic [7:0] rom1 [8] = '{8'h2e, 8'h71, 8'hc3, 8'h14, 8'h88, 8'h5b, 8'he0, 8'h3f};
   logic [7:0] rom2 [8] = '{8'ha1, 8'h06, 8'hd4, 8'h49, 8'hb2, 8'h17, 8'hfc, 8'h9a};

   exp_t sb[$];
   int   n_checks = 0;
   int   n_fail   = 0;

   rom_bus_arbiter #(.ADDR_W(3), .DATA_W(8)) dut (
      .clk      (clk),
      .rst      (rst),
      .req0     (req0),
      .req1     (req1),
      .addr0    (addr0),
      .addr1    (addr1),
      .ack0     (ack0),
      .ack1     (ack1),
      .rdata    (rdata),
      .rvalid   (rvalid),
      .rid      (rid),
      .cs       (cs),
      .read_en  (read_en),
      .rom_addr (rom_addr),
      .rom_data (rom_data)
   );

   always #5 clk = ~clk;

   // Shared bus: whichever bank is selected drives it.
   always_comb begin
      rom_data = 8'h00;
      if (cs == 2'b01)      rom_data = rom1[rom_addr];
      else if (cs == 2'b10) rom_data = rom2[rom_addr];
   end

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(negedge clk);
      n_checks++; if (cs !== 2'b00) begin n_fail++; $display("FAIL reset_cs: got %b want 00", cs); end
      n_checks++; if (read_en !== 1'b0) begin n_fail++; $display("FAIL reset_read_en: got %b want 0", read_en); end
      n_checks++; if (rom_addr !== 3'd0) begin n_fail++; $display("FAIL reset_rom_addr: got %0d want 0", rom_addr); end
      n_checks++; if (rdata !== 8'h00) begin n_fail++; $display("FAIL reset_rdata: got %h want 00", rdata); end
      n_checks++; if (rvalid !== 1'b0) begin n_fail++; $display("FAIL reset_rvalid: got %b want 0", rvalid); end
      n_checks++; if (rid !== 1'b0) begin n_fail++; $display("FAIL reset_rid: got %b want 0", rid); end
      n_checks++; if ({ack1, ack0} !== 2'b00) begin n_fail++; $display("FAIL reset_ack: got %b want 00", {ack1, ack0}); end
      rst = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_single(input logic id, input logic [3:0] a);
      exp_t e;
      logic [1:0] exp_cs;
      exp_cs = a[3] ? 2'b10 : 2'b01;
      if (id) begin req1 = 1'b1; addr1 = a; end
      else    begin req0 = 1'b1; addr0 = a; end
      sb.push_back('{id, a[3] ? rom2[a[2:0]] : rom1[a[2:0]]});
      @(negedge clk);
      n_checks++; if (cs !== exp_cs) begin n_fail++; $display("FAIL single%0d_cs: got %b want %b", id, cs, exp_cs); end
      n_checks++; if (rom_addr !== a[2:0]) begin n_fail++; $display("FAIL single%0d_rom_addr: got %0d want %0d", id, rom_addr, a[2:0]); end
      n_checks++; if (read_en !== 1'b1) begin n_fail++; $display("FAIL single%0d_read_en: got %b want 1", id, read_en); end
      n_checks++; if (rvalid !== 1'b0) begin n_fail++; $display("FAIL single%0d_early_rvalid: got %b want 0", id, rvalid); end
      @(negedge clk);
      e = sb.pop_front();
      n_checks++; if (rvalid !== 1'b1) begin n_fail++; $display("FAIL single%0d_rvalid: got %b want 1", id, rvalid); end
      n_checks++; if ({ack1, ack0} !== (e.id ? 2'b10 : 2'b01)) begin n_fail++; $display("FAIL single%0d_ack: got %b want id %0d", id, {ack1, ack0}, e.id); end
      n_checks++; if (rid !== e.id) begin n_fail++; $display("FAIL single%0d_rid: got %b want %b", id, rid, e.id); end
      n_checks++; if (rdata !== e.data) begin n_fail++; $display("FAIL single%0d_rdata: got %h want %h", id, rdata, e.data); end
      n_checks++; if ({cs, read_en} !== 3'b000) begin n_fail++; $display("FAIL single%0d_done_bus: got cs=%b re=%b want 00/0", id, cs, read_en); end
      req0 = 1'b0; req1 = 1'b0;
      @(negedge clk);
      n_checks++; if ({rvalid, ack1, ack0} !== 3'b000) begin n_fail++; $display("FAIL single%0d_after: got rvalid/acks %b want 000", id, {rvalid, ack1, ack0}); end
      repeat (2) @(negedge clk);
   endtask

   task automatic test_back_to_back();
      exp_t e;
      int   got = 0;
      int   last_t = -1;
      rst = 1'b1;
      req0 = 1'b1; addr0 = 4'b0011;
      req1 = 1'b1; addr1 = 4'b1010;
      sb.delete();
      for (int k = 0; k < 4; k++) begin
`ifdef ROM_ARB_FIXED_PRIO_EN
         sb.push_back('{1'b0, rom1[3]});
`else
         if (k % 2 == 0) sb.push_back('{1'b0, rom1[3]});
         else            sb.push_back('{1'b1, rom2[2]});
`endif
      end
      repeat (2) @(negedge clk);
      rst = 1'b0;
      for (int cyc = 0; cyc < 30 && got < 4; cyc++) begin
         @(negedge clk);
         n_checks++; if (cs === 2'b11) begin n_fail++; $display("FAIL b2b_cs_onehot: got %b want not 11", cs); end
         if (rvalid === 1'b1) begin
            e = sb.pop_front();
            n_checks++; if (rid !== e.id) begin n_fail++; $display("FAIL b2b_rid[%0d]: got %b want %b", got, rid, e.id); end
            n_checks++; if (rdata !== e.data) begin n_fail++; $display("FAIL b2b_rdata[%0d]: got %h want %h", got, rdata, e.data); end
            n_checks++; if ({ack1, ack0} !== (e.id ? 2'b10 : 2'b01)) begin n_fail++; $display("FAIL b2b_ack[%0d]: got %b want id %0d", got, {ack1, ack0}, e.id); end
            if (last_t >= 0) begin
               n_checks++; if (cyc - last_t != 3) begin n_fail++; $display("FAIL b2b_gap[%0d]: got %0d want 3", got, cyc - last_t); end
            end
            last_t = cyc;
            got++;
         end
      end
      n_checks++; if (got != 4) begin n_fail++; $display("FAIL b2b_count: got %0d want 4", got); end
      req0 = 1'b0; req1 = 1'b0;
      repeat (4) @(negedge clk);
      sb.delete();
   endtask

   task automatic test_reset_during_read();
      exp_t e;
      bit   seen = 1'b0;
      req0 = 1'b1; addr0 = 4'b0001;
      @(negedge clk);
      n_checks++; if (read_en !== 1'b1) begin n_fail++; $display("FAIL rstrd_in_read: got %b want 1", read_en); end
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      n_checks++; if ({cs, read_en} !== 3'b000) begin n_fail++; $display("FAIL rstrd_bus: got cs=%b re=%b want 00/0", cs, read_en); end
      n_checks++; if ({rvalid, ack1, ack0} !== 3'b000) begin n_fail++; $display("FAIL rstrd_no_ack: got %b want 000", {rvalid, ack1, ack0}); end
      n_checks++; if (dut.state_q !== IDLE) begin n_fail++; $display("FAIL rstrd_state: got %0d want %0d", dut.state_q, IDLE); end
      sb.push_back('{1'b0, rom1[1]});
      for (int cyc = 0; cyc < 8 && !seen; cyc++) begin
         @(negedge clk);
         if (rvalid === 1'b1) begin
            seen = 1'b1;
            e = sb.pop_front();
            n_checks++; if (rid !== e.id) begin n_fail++; $display("FAIL rstrd_rid: got %b want %b", rid, e.id); end
            n_checks++; if (rdata !== e.data) begin n_fail++; $display("FAIL rstrd_rdata: got %h want %h", rdata, e.data); end
            n_checks++; if (ack0 !== 1'b1) begin n_fail++; $display("FAIL rstrd_ack0: got %b want 1", ack0); end
            req0 = 1'b0;
         end
      end
      n_checks++; if (!seen) begin n_fail++; $display("FAIL rstrd_timeout: got no rvalid want one"); end
      req0 = 1'b0;
      repeat (3) @(negedge clk);
      sb.delete();
   endtask

   task automatic test_drop_during_read();
      exp_t e;
      req0 = 1'b1; addr0 = 4'b0000;
      sb.push_back('{1'b0, rom1[0]});
      @(negedge clk);
      n_checks++; if (cs !== 2'b01) begin n_fail++; $display("FAIL drop_cs: got %b want 01", cs); end
      req0 = 1'b0;
      @(negedge clk);
      e = sb.pop_front();
      n_checks++; if (ack0 !== 1'b1 || rvalid !== 1'b1) begin n_fail++; $display("FAIL drop_ack: got ack0=%b rvalid=%b want 1/1", ack0, rvalid); end
      n_checks++; if (rdata !== e.data) begin n_fail++; $display("FAIL drop_rdata: got %h want %h", rdata, e.data); end
      repeat (3) begin
         @(negedge clk);
         n_checks++; if ({rvalid, ack1, ack0, cs} !== 5'b0) begin n_fail++; $display("FAIL drop_quiet: got %b want 00000", {rvalid, ack1, ack0, cs}); end
      end
   endtask

   initial begin
      test_reset();
      test_single(1'b0, 4'b0101);
      test_single(1'b1, 4'b1111);
      test_back_to_back();
      test_reset_during_read();
      test_drop_during_read();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout want completion");
      $fatal(1, "watchdog expired");
   end

endmodule
